// File: rtl/ring_buffer_manager.sv
// Per-node ring buffer manager: through-ring (high) and local-injection (low) slots,
// local ejection, injection timestamping and starvation masking of the high buffer.
module ring_buffer_manager #(
    parameter int NODE_ID      = 0,
    parameter int PACKET_SIZE  = 49,
    parameter int BUFFER_SIZE  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PACKET_SIZE-1:0]            ring_in_pkt,
    output logic                              ring_ready,
    input  logic [PACKET_SIZE-1:0]            inj_pkt,
    input  logic                              inj_valid,
    output logic                              inj_ready,
    input  logic [15:0]                       grant_pos,
    input  logic                              grant_valid,
    input  logic                              grant_in_high,
    output logic [PACKET_SIZE*BUFFER_SIZE-1:0] buffer_high_prior,
    output logic [PACKET_SIZE*BUFFER_SIZE-1:0] buffer_low_prior,
    output logic [16*BUFFER_SIZE-1:0]         buffer_high_prior_route_info,
    output logic [16*BUFFER_SIZE-1:0]         buffer_low_prior_route_info,
    output logic [PACKET_SIZE-1:0]            eject_pkt,
    output logic                              overflow,
    output logic                              grant_err
);
    // state  | meaning
    // IDLE   | both buffers empty
    // ACTIVE | at least one slot valid
    // STARVE | high outputs masked until a low grant or the low buffer empties
    typedef enum logic [1:0] {IDLE, ACTIVE, STARVE} state_t;

    localparam int          V     = PACKET_SIZE - 1;
    localparam int          IW    = $clog2(BUFFER_SIZE);
    localparam logic [3:0]  NODE  = 4'(NODE_ID);
    localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);
    localparam logic [15:0] NSLOT = 16'(BUFFER_SIZE);

    logic [PACKET_SIZE-1:0] hi_q [BUFFER_SIZE];
    logic [PACKET_SIZE-1:0] lo_q [BUFFER_SIZE];
    logic [PACKET_SIZE-1:0] eject_q, inj_stamped;
    logic [15:0]            ts_q;
    logic [3:0]             starv_q, starv_nx;
    state_t                 st_q, st_nx;
    logic                   ring_rdy_q, inj_rdy_q, ovf_q, gerr_q;

    logic [BUFFER_SIZE-1:0] hi_vld, lo_vld, hi_vld_nx, lo_vld_nx;
    logic [IW-1:0]          hi_sel, lo_sel, g_slot;
    logic ring_local, ring_wr, ring_drop, inj_local, inj_acc, lo_wr;
    logic g_hit, g_hi, g_lo, g_bad, mask_high;

    function automatic logic [15:0] route_of(input logic [PACKET_SIZE-1:0] p);
        return (p[V] && (p[31:28] != NODE)) ? 16'h0001 : 16'h0000;
    endfunction

    assign ring_local = ring_in_pkt[V] && (ring_in_pkt[31:28] == NODE);
    // ring_rdy_q mirrors "a high slot is free" for the current cycle, so it gates writes directly
    assign ring_wr    = ring_in_pkt[V] && !ring_local && ring_rdy_q;
    assign ring_drop  = ring_in_pkt[V] && !ring_local && !ring_rdy_q;

    assign inj_ready  = inj_rdy_q && !ring_local;
    assign inj_acc    = inj_valid && inj_ready;
    assign inj_local  = (inj_pkt[31:28] == NODE);
    assign lo_wr      = inj_acc && !inj_local;

    assign g_slot = grant_pos[IW-1:0];
    assign g_hit  = grant_valid && (grant_pos < NSLOT) &&
                    (grant_in_high ? hi_vld[g_slot] : lo_vld[g_slot]);
    assign g_hi   = g_hit && grant_in_high;
    assign g_lo   = g_hit && !grant_in_high;
    assign g_bad  = grant_valid && !g_hit;

    assign mask_high  = (st_q == STARVE);
    assign ring_ready = ring_rdy_q;
    assign eject_pkt  = eject_q;
    assign overflow   = ovf_q;
    assign grant_err  = gerr_q;

    always_comb begin
        inj_stamped           = inj_pkt;
        inj_stamped[V]        = 1'b1;
        inj_stamped[V-1 -: 16] = ts_q;
    end

    // Write slots come from pre-grant occupancy: the lowest-index free slot.
    always_comb begin
        hi_vld = '0;
        lo_vld = '0;
        hi_sel = '0;
        lo_sel = '0;
        for (int i = BUFFER_SIZE - 1; i >= 0; i--) begin
            hi_vld[i] = hi_q[i][V];
            lo_vld[i] = lo_q[i][V];
            if (!hi_q[i][V]) hi_sel = IW'(i);
            if (!lo_q[i][V]) lo_sel = IW'(i);
        end
    end

    always_comb begin
        hi_vld_nx = hi_vld;
        lo_vld_nx = lo_vld;
        if (g_hi)    hi_vld_nx[g_slot] = 1'b0;
        if (ring_wr) hi_vld_nx[hi_sel] = 1'b1;
        if (g_lo)    lo_vld_nx[g_slot] = 1'b0;
        if (lo_wr)   lo_vld_nx[lo_sel] = 1'b1;

        starv_nx = starv_q;
        if (g_lo || !(|lo_vld))
            starv_nx = 4'd0;
        else if (g_hi && (starv_q != 4'hF))
            starv_nx = starv_q + 4'd1;

        if (starv_nx >= LIMIT)
            st_nx = STARVE;
        else if ((|hi_vld_nx) || (|lo_vld_nx))
            st_nx = ACTIVE;
        else
            st_nx = IDLE;
    end

    always_comb begin
        buffer_high_prior            = '0;
        buffer_low_prior             = '0;
        buffer_high_prior_route_info = '0;
        buffer_low_prior_route_info  = '0;
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            buffer_high_prior[i*PACKET_SIZE +: PACKET_SIZE] =
                {hi_q[i][V] & ~mask_high, hi_q[i][V-1:0]};
            buffer_low_prior[i*PACKET_SIZE +: PACKET_SIZE] = lo_q[i];
            buffer_high_prior_route_info[i*16 +: 16] = mask_high ? 16'h0000 : route_of(hi_q[i]);
            buffer_low_prior_route_info[i*16 +: 16]  = route_of(lo_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                hi_q[i] <= '0;
                lo_q[i] <= '0;
            end
            eject_q    <= '0;
            ts_q       <= '0;
            starv_q    <= '0;
            st_q       <= IDLE;
            ring_rdy_q <= 1'b0;
            inj_rdy_q  <= 1'b0;
            ovf_q      <= 1'b0;
            gerr_q     <= 1'b0;
        end else begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                if (g_hi && (g_slot == IW'(i)))    hi_q[i] <= '0;
                if (ring_wr && (hi_sel == IW'(i))) hi_q[i] <= ring_in_pkt;
                if (g_lo && (g_slot == IW'(i)))    lo_q[i] <= '0;
                if (lo_wr && (lo_sel == IW'(i)))   lo_q[i] <= inj_stamped;
            end
            eject_q    <= ring_local ? ring_in_pkt :
                          ((inj_acc && inj_local) ? inj_stamped : '0);
            ts_q       <= ts_q + 16'd1;
            starv_q    <= starv_nx;
            st_q       <= st_nx;
            ring_rdy_q <= ~&hi_vld_nx;
            inj_rdy_q  <= ~&lo_vld_nx;
            if (ring_drop) ovf_q  <= 1'b1;
            if (g_bad)     gerr_q <= 1'b1;
        end
    end
endmodule
